// File: rtl/mem_resp_pkg.sv
// Shared constants and helpers for the load-response router: the forced-completion
// data pattern, window decode with clamp, and tag width.
package mem_resp_pkg;

   localparam logic [31:0] DEAD_DATA = 32'hdeadbeef;

   function automatic int src_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Window field 0 is data memory; any field past the last window maps to the last source.
   function automatic int src_idx(input logic [31:0] f, input int n);
      if (f == 32'd0)
         return 0;
      else if (f > 32'(n - 1))
         return n - 1;
      else
         return int'(f);
   endfunction

endpackage

// File: rtl/mem_resp_tag_fifo.sv
// In-order FIFO of source tags for outstanding loads; pointers carry one extra wrap bit.
module mem_resp_tag_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 din,
   output logic [W-1:0]                 dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   wr_ptr, rd_ptr;
   logic [W-1:0]  mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= din;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;
   assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mem_resp_router.sv
// In-order load-response router: data memory plus MMIO windows, per-source holding registers.
// Build option RESP_TIMEOUT_EN force-completes a head load left unanswered for TIMEOUT cycles.
module mem_resp_router
   import mem_resp_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int N_SRC   = 2,
   parameter int DEPTH   = 4,
   parameter int WIN_LSB = 8,
   parameter int WIN_MSB = 15,
   parameter int TIMEOUT = 64,
   localparam int SRC_W  = src_w(N_SRC),
   localparam int CW     = $clog2(DEPTH+1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [N_SRC-1:0]          src_rsp_valid,
   input  logic [N_SRC*DATA_W-1:0]   src_rsp_data,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_data,
   output logic [SRC_W-1:0]          rsp_src,
   output logic                      rsp_err,
   output logic                      err_spurious,
   output logic                      err_overflow,
   output logic [CW-1:0]             outstanding
);

   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("TIMEOUT must be at least 2");
   end
   if (N_SRC < 2 || DEPTH < 2) begin : g_bad_size
      $error("N_SRC and DEPTH must be at least 2");
   end

   logic [WIN_MSB-WIN_LSB:0] field;
   logic [SRC_W-1:0]         req_src, t;
   logic                     full, empty, push, pop, forced;
   logic [N_SRC-1:0]         push_sel, pop_sel, hold_v;
   logic [CW-1:0]            pend [N_SRC];
   logic [DATA_W-1:0]        hold_d [N_SRC];
   logic                     unused_addr;

   assign field       = req_addr[WIN_MSB:WIN_LSB];
   assign req_src     = SRC_W'(src_idx(32'(field), N_SRC));
   assign unused_addr = ^req_addr;
   assign req_ready   = !full;
   assign push        = req_valid && !full;
   assign pop         = rsp_valid && rsp_ready;

   mem_resp_tag_fifo #(.DEPTH(DEPTH), .W(SRC_W)) u_tags (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (req_src),
      .dout  (t),
      .full  (full),
      .empty (empty),
      .count (outstanding)
   );

   always_comb begin
      push_sel = '0;
      pop_sel  = '0;
      for (int i = 0; i < N_SRC; i++) begin
         push_sel[i] = push && (req_src == SRC_W'(i));
         pop_sel[i]  = pop && (t == SRC_W'(i));
      end
   end

`ifdef RESP_TIMEOUT_EN
   localparam int                TW   = $clog2(TIMEOUT+1);
   localparam logic [DATA_W-1:0] DEAD = DATA_W'(DEAD_DATA);

   logic [TW-1:0] age;
   logic [CW-1:0] drop [N_SRC];

   // Head age restarts whenever the head leaves (pop) or the FIFO drains.
   always_ff @(posedge clk) begin
      if (rst || pop || empty)
         age <= '0;
      else if (age != TW'(TIMEOUT))
         age <= age + TW'(1);
   end

   assign forced    = !empty && !hold_v[t] && (age == TW'(TIMEOUT));
   assign rsp_valid = !empty && (hold_v[t] || forced);
   assign rsp_data  = !rsp_valid ? '0 : (hold_v[t] ? hold_d[t] : DEAD);
   assign rsp_err   = forced;
`else
   assign forced    = 1'b0;
   assign rsp_valid = !empty && hold_v[t];
   assign rsp_data  = rsp_valid ? hold_d[t] : '0;
   assign rsp_err   = 1'b0;
`endif

   assign rsp_src = rsp_valid ? t : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_v       <= '0;
         err_spurious <= 1'b0;
         err_overflow <= 1'b0;
         for (int i = 0; i < N_SRC; i++) begin
            pend[i]   <= '0;
            hold_d[i] <= '0;
`ifdef RESP_TIMEOUT_EN
            drop[i]   <= '0;
`endif
         end
      end else begin
         for (int i = 0; i < N_SRC; i++) begin
            if (push_sel[i] && !pop_sel[i])
               pend[i] <= pend[i] + CW'(1);
            else if (pop_sel[i] && !push_sel[i])
               pend[i] <= pend[i] - CW'(1);
            if (pop_sel[i])
               hold_v[i] <= 1'b0;
            if (src_rsp_valid[i]) begin
`ifdef RESP_TIMEOUT_EN
               // Late answers to force-completed loads are swallowed; one landing on the
               // very cycle its load is forced out is consumed without booking a drop.
               if (drop[i] != '0) begin
                  if (!(forced && pop_sel[i]))
                     drop[i] <= drop[i] - CW'(1);
               end else if (forced && pop_sel[i]) begin
               end else
`endif
               if (pend[i] == '0)
                  err_spurious <= 1'b1;
               else if (hold_v[i] && !pop_sel[i])
                  err_overflow <= 1'b1;
               else begin
                  hold_d[i] <= src_rsp_data[i*DATA_W +: DATA_W];
                  hold_v[i] <= 1'b1;
               end
            end
`ifdef RESP_TIMEOUT_EN
            else if (forced && pop_sel[i])
               drop[i] <= drop[i] + CW'(1);
`endif
         end
      end
   end

endmodule

// File: tb/tb_mem_resp_router.sv
// Directed bench for mem_resp_router with default parameters (two sources, depth 4).
module tb_mem_resp_router;

   localparam int DW = 32;
   localparam int NS = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             rsp_ready = 1'b0;
   logic [31:0]      req_addr = '0;
   logic [NS-1:0]    src_rsp_valid = '0;
   logic [NS*DW-1:0] src_rsp_data = '0;
   logic             req_ready, rsp_valid, rsp_err, err_spurious, err_overflow;
   logic [DW-1:0]    rsp_data;
   logic [0:0]       rsp_src;
   logic [2:0]       outstanding;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_resp_router dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .src_rsp_valid (src_rsp_valid),
      .src_rsp_data  (src_rsp_data),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_src       (rsp_src),
      .rsp_err       (rsp_err),
      .err_spurious  (err_spurious),
      .err_overflow  (err_overflow),
      .outstanding   (outstanding)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (rsp_valid !== 1'b0)    begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      checks++; if (rsp_data !== 32'h0)    begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
      checks++; if (rsp_src !== 1'b0)      begin errors++; $display("FAIL reset_rsp_src got %b want 0", rsp_src); end
      checks++; if (rsp_err !== 1'b0)      begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
      checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL reset_err_spurious got %b want 0", err_spurious); end
      checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL reset_err_overflow got %b want 0", err_overflow); end
      checks++; if (outstanding !== 3'd0)  begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
      checks++; if (req_ready !== 1'b1)    begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
   endtask

   task automatic test_single();
      req_valid = 1'b1; req_addr = 32'h0000_0040;
      tick();
      req_valid = 1'b0;
      checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_outstanding got %0d want 1", outstanding); end
      checks++; if (rsp_valid !== 1'b0)   begin errors++; $display("FAIL single_early_valid got %b want 0", rsp_valid); end
      tick();
      src_rsp_valid = 2'b01; src_rsp_data = {32'h0, 32'h1234_5678};
      tick();
      src_rsp_valid = 2'b00;
      checks++; if (rsp_valid !== 1'b1)        begin errors++; $display("FAIL single_valid got %b want 1", rsp_valid); end
      checks++; if (rsp_data !== 32'h1234_5678) begin errors++; $display("FAIL single_data got %h want 12345678", rsp_data); end
      checks++; if (rsp_src !== 1'b0)          begin errors++; $display("FAIL single_src got %b want 0", rsp_src); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL single_drain got %0d want 0", outstanding); end
      checks++; if (rsp_valid !== 1'b0)   begin errors++; $display("FAIL single_after_pop got %b want 0", rsp_valid); end
   endtask

   task automatic test_order();
      req_valid = 1'b1; req_addr = 32'h0000_0100;
      tick();
      req_addr = 32'h0000_0000;
      tick();
      req_valid = 1'b0;
      checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL order_outstanding got %0d want 2", outstanding); end
      src_rsp_valid = 2'b01; src_rsp_data = {32'h0, 32'hAAAA_AAAA};
      tick();
      src_rsp_valid = 2'b00;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL order_younger_waits got %b want 0", rsp_valid); end
      tick();
      src_rsp_valid = 2'b10; src_rsp_data = {32'hBBBB_BBBB, 32'h0};
      tick();
      src_rsp_valid = 2'b00;
      checks++; if (rsp_valid !== 1'b1)         begin errors++; $display("FAIL order_first_valid got %b want 1", rsp_valid); end
      checks++; if (rsp_data !== 32'hBBBB_BBBB) begin errors++; $display("FAIL order_first_data got %h want bbbbbbbb", rsp_data); end
      checks++; if (rsp_src !== 1'b1)           begin errors++; $display("FAIL order_first_src got %b want 1", rsp_src); end
      rsp_ready = 1'b1;
      tick();
      checks++; if (rsp_data !== 32'hAAAA_AAAA) begin errors++; $display("FAIL order_second_data got %h want aaaaaaaa", rsp_data); end
      checks++; if (rsp_src !== 1'b0)           begin errors++; $display("FAIL order_second_src got %b want 0", rsp_src); end
      tick();
      rsp_ready = 1'b0;
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL order_drain got %0d want 0", outstanding); end
   endtask

   // Tags issued: src0, src1, src1 (field 5 clamps to last source), src0.
   task automatic test_full();
      req_valid = 1'b1;
      req_addr = 32'h0000_0000; tick();
      req_addr = 32'h0000_0100; tick();
      req_addr = 32'h0000_0500; tick();
      req_addr = 32'h0000_0004; tick();
      checks++; if (req_ready !== 1'b0)   begin errors++; $display("FAIL full_req_ready got %b want 0", req_ready); end
      checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_outstanding got %0d want 4", outstanding); end
      req_addr = 32'h0000_0000; tick();
      req_valid = 1'b0;
      checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_no_push got %0d want 4", outstanding); end
      rsp_ready = 1'b1;
      src_rsp_valid = 2'b11; src_rsp_data = {32'hD1D1_0001, 32'hD0D0_0000};
      tick();
      checks++; if (rsp_data !== 32'hD0D0_0000) begin errors++; $display("FAIL full_rsp0 got %h want d0d00000", rsp_data); end
      // source 0 answers again while its holding register is being popped
      src_rsp_valid = 2'b01; src_rsp_data = {32'h0, 32'hD3D3_0003};
      tick();
      checks++; if (rsp_data !== 32'hD1D1_0001) begin errors++; $display("FAIL full_rsp1 got %h want d1d10001", rsp_data); end
      checks++; if (rsp_src !== 1'b1)           begin errors++; $display("FAIL full_rsp1_src got %b want 1", rsp_src); end
      src_rsp_valid = 2'b10; src_rsp_data = {32'hD2D2_0002, 32'h0};
      tick();
      src_rsp_valid = 2'b00;
      checks++; if (rsp_data !== 32'hD2D2_0002) begin errors++; $display("FAIL full_rsp2 got %h want d2d20002", rsp_data); end
      checks++; if (rsp_src !== 1'b1)           begin errors++; $display("FAIL full_rsp2_src got %b want 1", rsp_src); end
      tick();
      checks++; if (rsp_data !== 32'hD3D3_0003) begin errors++; $display("FAIL full_rsp3 got %h want d3d30003", rsp_data); end
      checks++; if (rsp_src !== 1'b0)           begin errors++; $display("FAIL full_rsp3_src got %b want 0", rsp_src); end
      tick();
      rsp_ready = 1'b0;
      checks++; if (outstanding !== 3'd0)  begin errors++; $display("FAIL full_drain got %0d want 0", outstanding); end
      checks++; if (req_ready !== 1'b1)    begin errors++; $display("FAIL full_ready_back got %b want 1", req_ready); end
      checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL full_no_overflow got %b want 0", err_overflow); end
      checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL full_no_spurious got %b want 0", err_spurious); end
   endtask

   task automatic test_back_to_back();
      req_valid = 1'b1; req_addr = 32'h0000_0000;
      tick();
      req_valid = 1'b0;
      src_rsp_valid = 2'b01; src_rsp_data = {32'h0, 32'hE0E0_E0E0};
      tick();
      src_rsp_valid = 2'b00;
      req_valid = 1'b1; req_addr = 32'h0000_0100; rsp_ready = 1'b1;
      tick();
      req_valid = 1'b0; rsp_ready = 1'b0;
      checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL b2b_outstanding got %0d want 1", outstanding); end
      checks++; if (rsp_valid !== 1'b0)   begin errors++; $display("FAIL b2b_head_waits got %b want 0", rsp_valid); end
      src_rsp_valid = 2'b10; src_rsp_data = {32'hE1E1_E1E1, 32'h0};
      tick();
      src_rsp_valid = 2'b00;
      checks++; if (rsp_data !== 32'hE1E1_E1E1) begin errors++; $display("FAIL b2b_data got %h want e1e1e1e1", rsp_data); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL b2b_drain got %0d want 0", outstanding); end
   endtask

   task automatic test_spurious();
      src_rsp_valid = 2'b10; src_rsp_data = {32'h5555_5555, 32'h0};
      tick();
      src_rsp_valid = 2'b00;
      checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL spurious_flag got %b want 1", err_spurious); end
      checks++; if (rsp_valid !== 1'b0)    begin errors++; $display("FAIL spurious_no_rsp got %b want 0", rsp_valid); end
      tick();
      tick();
      checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL spurious_sticky got %b want 1", err_spurious); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL spurious_reset got %b want 0", err_spurious); end
   endtask

   task automatic test_overflow();
      req_valid = 1'b1; req_addr = 32'h0000_0100;
      tick();
      tick();
      req_valid = 1'b0;
      src_rsp_valid = 2'b10; src_rsp_data = {32'hF1F1_F1F1, 32'h0};
      tick();
      src_rsp_data = {32'hF2F2_F2F2, 32'h0};
      tick();
      src_rsp_valid = 2'b00;
      checks++; if (err_overflow !== 1'b1)      begin errors++; $display("FAIL overflow_flag got %b want 1", err_overflow); end
      checks++; if (rsp_data !== 32'hF1F1_F1F1) begin errors++; $display("FAIL overflow_kept got %h want f1f1f1f1", rsp_data); end
      checks++; if (err_spurious !== 1'b0)      begin errors++; $display("FAIL overflow_not_spurious got %b want 0", err_spurious); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0)   begin errors++; $display("FAIL overflow_second_lost got %b want 0", rsp_valid); end
      checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL overflow_outstanding got %0d want 1", outstanding); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (outstanding !== 3'd0)  begin errors++; $display("FAIL overflow_reset_fifo got %0d want 0", outstanding); end
      checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL overflow_reset_flag got %b want 0", err_overflow); end
   endtask

`ifdef RESP_TIMEOUT_EN
   task automatic test_timeout();
      int cnt;
      req_valid = 1'b1; req_addr = 32'h0000_0100;
      tick();
      req_valid = 1'b0;
      cnt = 0;
      while (cnt < 200 && !rsp_valid) begin
         tick();
         cnt++;
      end
      checks++; if (cnt !== 64)               begin errors++; $display("FAIL timeout_cycles got %0d want 64", cnt); end
      checks++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL timeout_data got %h want deadbeef", rsp_data); end
      checks++; if (rsp_err !== 1'b1)          begin errors++; $display("FAIL timeout_err got %b want 1", rsp_err); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL timeout_pop got %0d want 0", outstanding); end
      src_rsp_valid = 2'b10; src_rsp_data = {32'h7777_7777, 32'h0};
      tick();
      src_rsp_valid = 2'b00;
      checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL timeout_late_silent got %b want 0", err_spurious); end
      checks++; if (rsp_valid !== 1'b0)    begin errors++; $display("FAIL timeout_late_no_rsp got %b want 0", rsp_valid); end
      req_valid = 1'b1; req_addr = 32'h0000_0100;
      tick();
      req_valid = 1'b0;
      src_rsp_valid = 2'b10; src_rsp_data = {32'h8888_8888, 32'h0};
      tick();
      src_rsp_valid = 2'b00;
      checks++; if (rsp_data !== 32'h8888_8888) begin errors++; $display("FAIL timeout_next_data got %h want 88888888", rsp_data); end
      checks++; if (rsp_err !== 1'b0)           begin errors++; $display("FAIL timeout_next_err got %b want 0", rsp_err); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_order();
      test_full();
      test_back_to_back();
      test_spurious();
      test_overflow();
`ifdef RESP_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
